// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Owner / mux select encoding.
  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

endpackage

// File: rtl/MUX_32_2_1.sv
// 32-bit two-input multiplexer: Y = Sel ? B : A.
module MUX_32_2_1 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Sel,
  output logic [31:0] Y
);

  // Pure select, no state.
  always_comb begin
    Y = Sel ? B : A;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch (I) and load/store (D).
// Round-robin on contention, one outstanding transaction, optional ready timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        i_ack,
  output logic        d_ack,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam bit              ToEn   = (TIMEOUT_CYCLES != 0);
  // Last counter value before the timeout fires; unused when the timeout is disabled.
  localparam logic [TO_W-1:0] ToLast = ToEn ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;  // current owner while busy, last owner otherwise
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            busy;
  logic [31:0]     mux_addr;
  logic [31:0]     mux_wdata;

  // Address steering: A = fetch, B = load/store.
  MUX_32_2_1 u_addr_mux (
    .A   (i_addr),
    .B   (d_addr),
    .Sel (owner_q),
    .Y   (mux_addr)
  );

  // Write-data steering: fetch never writes, so its side is tied to zero.
  MUX_32_2_1 u_wdata_mux (
    .A   (32'h0),
    .B   (d_wdata),
    .Sel (owner_q),
    .Y   (mux_wdata)
  );

  // State, owner, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= OwnI;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: arbitration in idle, completion or timeout while busy.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          if (i_req && d_req) begin
            owner_d = ~owner_q;
          end else begin
            owner_d = d_req ? OwnD : OwnI;
          end
          state_d = (owner_d == OwnD) ? StBusyD : StBusyI;
          cnt_d   = '0;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ready) begin
          // Ready wins over a timeout expiring in the same cycle.
          rdata_d = (owner_q == OwnD && d_we) ? 32'h0 : mem_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (ToEn && cnt_q == ToLast) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: memory side only driven while busy, ack pulses in the response state.
  always_comb begin
    busy       = (state_q == StBusyI) || (state_q == StBusyD);
    mem_req    = busy;
    mem_we     = busy && (owner_q == OwnD) && d_we;
    mem_addr   = busy ? mux_addr : 32'h0;
    mem_wdata  = busy ? mux_wdata : 32'h0;
    i_ack      = (state_q == StResp) && (owner_q == OwnI);
    d_ack      = (state_q == StResp) && (owner_q == OwnD);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// u_dut uses the default timeout; u_dut_to shares its inputs and uses TIMEOUT_CYCLES = 4.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        i_ack, d_ack, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;

  logic        t_i_ack, t_d_ack, t_resp_err, t_mem_req, t_mem_we;
  logic [31:0] t_resp_rdata, t_mem_addr, t_mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .i_ack      (i_ack),
    .d_ack      (d_ack),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (4),
    .TO_W           (8)
  ) u_dut_to (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .i_ack      (t_i_ack),
    .d_ack      (t_d_ack),
    .resp_rdata (t_resp_rdata),
    .resp_err   (t_resp_err),
    .mem_req    (t_mem_req),
    .mem_we     (t_mem_we),
    .mem_addr   (t_mem_addr),
    .mem_wdata  (t_mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling mid-cycle.
  task automatic settle();
    #3;
  endtask

  // Two reset cycles with reset-state checks; returns at the drive point of cycle 0.
  task automatic do_reset();
    rst_n     = 1'b0;
    i_req     = 1'b0;
    i_addr    = 32'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    cyc();
    cyc();
    settle();
    check_eq("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_err", {31'h0, resp_err}, 32'h0);
    check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    bit exp_d;

    // Zero-wait fetch.
    do_reset();
    i_req     = 1'b1;
    i_addr    = 32'h0000_0040;
    mem_ready = 1'b1;
    mem_rdata = 32'h8C01_0004;
    settle();
    check_eq("t1_c0_mem_req", {31'h0, mem_req}, 32'h0);
    cyc();
    settle();
    check_eq("t1_c1_mem_req", {31'h0, mem_req}, 32'h1);
    check_eq("t1_c1_mem_addr", mem_addr, 32'h40);
    check_eq("t1_c1_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("t1_c1_mem_wdata", mem_wdata, 32'h0);
    check_eq("t1_c1_i_ack", {31'h0, i_ack}, 32'h0);
    cyc();
    i_req = 1'b0;
    settle();
    check_eq("t1_c2_i_ack", {31'h0, i_ack}, 32'h1);
    check_eq("t1_c2_d_ack", {31'h0, d_ack}, 32'h0);
    check_eq("t1_c2_rdata", resp_rdata, 32'h8C01_0004);
    check_eq("t1_c2_err", {31'h0, resp_err}, 32'h0);

    // Sustained contention: D first (store), then strict alternation.
    do_reset();
    i_req     = 1'b1;
    i_addr    = 32'h0000_0200;
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h0000_0100;
    d_wdata   = 32'hDEAD_BEEF;
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      settle();
      exp_d = (((c - 1) / 3) % 2) == 0;
      case ((c - 1) % 3)
        0: begin
          check_eq("t2_busy_req", {31'h0, mem_req}, 32'h1);
          check_eq("t2_busy_addr", mem_addr, exp_d ? 32'h100 : 32'h200);
          check_eq("t2_busy_we", {31'h0, mem_we}, {31'h0, exp_d});
          check_eq("t2_busy_wdata", mem_wdata, exp_d ? 32'hDEAD_BEEF : 32'h0);
        end
        1: begin
          check_eq("t2_resp_acks", {30'h0, i_ack, d_ack}, exp_d ? 32'h1 : 32'h2);
          check_eq("t2_resp_rdata", resp_rdata, exp_d ? 32'h0 : 32'h1111_2222);
        end
        default: begin
          check_eq("t2_idle_req", {31'h0, mem_req}, 32'h0);
        end
      endcase
    end

    // Load with five wait cycles.
    do_reset();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0300;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      settle();
      check_eq("t3_wait_req", {31'h0, mem_req}, 32'h1);
      check_eq("t3_wait_addr", mem_addr, 32'h300);
      check_eq("t3_wait_ack", {31'h0, d_ack}, 32'h0);
    end
    cyc();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    settle();
    check_eq("t3_ready_req", {31'h0, mem_req}, 32'h1);
    check_eq("t3_ready_ack", {31'h0, d_ack}, 32'h0);
    cyc();
    mem_ready = 1'b0;
    d_req     = 1'b0;
    settle();
    check_eq("t3_d_ack", {31'h0, d_ack}, 32'h1);
    check_eq("t3_rdata", resp_rdata, 32'hCAFE_F00D);

    // Timeout (TIMEOUT_CYCLES = 4) followed by a normal load.
    do_reset();
    i_req     = 1'b1;
    i_addr    = 32'h0000_0500;
    mem_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      settle();
      check_eq("t4_busy_req", {31'h0, t_mem_req}, 32'h1);
      check_eq("t4_busy_ack", {31'h0, t_i_ack}, 32'h0);
    end
    cyc();
    i_req = 1'b0;
    settle();
    check_eq("t4_to_ack", {31'h0, t_i_ack}, 32'h1);
    check_eq("t4_to_err", {31'h0, t_resp_err}, 32'h1);
    check_eq("t4_to_rdata", t_resp_rdata, 32'h0);
    check_eq("t4_to_mem_req", {31'h0, t_mem_req}, 32'h0);
    cyc();
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0000_0600;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    cyc();
    settle();
    check_eq("t4_next_req", {31'h0, t_mem_req}, 32'h1);
    check_eq("t4_next_addr", t_mem_addr, 32'h600);
    check_eq("t4_next_we", {31'h0, t_mem_we}, 32'h0);
    cyc();
    d_req     = 1'b0;
    mem_ready = 1'b0;
    settle();
    check_eq("t4_next_ack", {31'h0, t_d_ack}, 32'h1);
    check_eq("t4_next_err", {31'h0, t_resp_err}, 32'h0);
    check_eq("t4_next_rdata", t_resp_rdata, 32'h1234_5678);

    // Ready coincident with timeout expiry counts as success.
    do_reset();
    i_req     = 1'b1;
    i_addr    = 32'h0000_0700;
    mem_rdata = 32'hA5A5_A5A5;
    cyc();
    cyc();
    cyc();
    cyc();
    mem_ready = 1'b1;
    settle();
    check_eq("t5_last_req", {31'h0, t_mem_req}, 32'h1);
    check_eq("t5_last_addr", t_mem_addr, 32'h700);
    cyc();
    i_req     = 1'b0;
    mem_ready = 1'b0;
    settle();
    check_eq("t5_ack", {31'h0, t_i_ack}, 32'h1);
    check_eq("t5_err", {31'h0, t_resp_err}, 32'h0);
    check_eq("t5_rdata", t_resp_rdata, 32'hA5A5_A5A5);

    // Reset during BUSY_D abandons the load; held request is re-granted afterwards.
    do_reset();
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0000_0800;
    mem_rdata = 32'h0BAD_F00D;
    cyc();
    settle();
    check_eq("t6_busy_req", {31'h0, mem_req}, 32'h1);
    cyc();
    rst_n = 1'b0;
    settle();
    check_eq("t6_busy2_req", {31'h0, mem_req}, 32'h1);
    cyc();
    rst_n = 1'b1;
    settle();
    check_eq("t6_rst_req", {31'h0, mem_req}, 32'h0);
    check_eq("t6_rst_ack", {31'h0, d_ack}, 32'h0);
    cyc();
    mem_ready = 1'b1;
    settle();
    check_eq("t6_regrant_req", {31'h0, mem_req}, 32'h1);
    check_eq("t6_regrant_addr", mem_addr, 32'h800);
    check_eq("t6_regrant_ack", {31'h0, d_ack}, 32'h0);
    cyc();
    d_req     = 1'b0;
    mem_ready = 1'b0;
    settle();
    check_eq("t6_ack", {31'h0, d_ack}, 32'h1);
    check_eq("t6_rdata", resp_rdata, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
